// File: rtl/mmcm_reset_sequencer.sv
// MMCM reset sequencer: pulses MMCM RST, waits for lock, and releases o_rst_n after a stable-lock window.
// Define MMCM_RETRY_CNT_EN to build the saturating lock-timeout counter; otherwise o_retry_cnt is tied to 0.
module mmcm_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_locked,
  output logic       o_mmcm_rst,
  output logic       o_rst_n,
  output logic [1:0] o_state,
  output logic [7:0] o_retry_cnt
);

  typedef enum logic [1:0] {
    RESET_PULSE = 2'd0,
    WAIT_LOCK   = 2'd1,
    STABLE      = 2'd2,
    RUN         = 2'd3
  } state_t;

  localparam logic [23:0] RST_LAST    = 24'(RST_CYCLES - 1);
  localparam logic [23:0] LOCK_LAST   = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] STABLE_LAST = 24'(STABLE_CYCLES - 1);

  state_t      state;
  state_t      state_nx;
  logic [23:0] cnt;
  logic        lk_meta;
  logic        lk;

  // LOCKED comes from the MMCM asynchronously; only the second flop is used.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= i_locked;
      lk      <= lk_meta;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      RESET_PULSE: if (cnt == RST_LAST) state_nx = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lk)                    state_nx = STABLE;
        else if (cnt == LOCK_LAST) state_nx = RESET_PULSE;
      end
      STABLE: begin
        if (!lk)                     state_nx = RESET_PULSE;
        else if (cnt == STABLE_LAST) state_nx = RUN;
      end
      RUN:     if (!lk) state_nx = RESET_PULSE;
      default: state_nx = RESET_PULSE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the transition edge itself.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= RESET_PULSE;
      cnt        <= '0;
      o_mmcm_rst <= 1'b1;
      o_rst_n    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= (state_nx != state) ? 24'd0 : cnt + 24'd1;
      o_mmcm_rst <= (state_nx == RESET_PULSE);
      o_rst_n    <= (state_nx == RUN);
    end
  end

  assign o_state = state;

`ifdef MMCM_RETRY_CNT_EN
  logic [7:0] retry_cnt;
  logic       timeout;

  // Only WAIT_LOCK expiries count; lock losses later in the sequence do not.
  assign timeout = (state == WAIT_LOCK) && !lk && (cnt == LOCK_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      retry_cnt <= 8'd0;
    end else if (timeout && (retry_cnt != 8'hFF)) begin
      retry_cnt <= retry_cnt + 8'd1;
    end
  end

  assign o_retry_cnt = retry_cnt;
`else
  assign o_retry_cnt = 8'd0;
`endif

endmodule

// File: doc/mmcm_reset_sequencer.md
MMCM_RESET_SEQUENCER -- requirements
Module: mmcm_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: number of cycles o_mmcm_rst is held per reset pulse (legal range 1..2^24).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536: WAIT_LOCK cycles allowed before a retry (legal range 1..2^24).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: cycles of continuous lock required before release (legal range 1..2^24).
REQ-004 SHALL have port i_clk, input, 1 bit: free-running MMCM input reference clock, sole clock.
REQ-005 SHALL have port i_rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port i_locked, input, 1 bit: MMCM LOCKED, asynchronous to i_clk.
REQ-007 SHALL have port o_mmcm_rst, output, 1 bit: drives MMCM RST, active high.
REQ-008 SHALL have port o_rst_n, output, 1 bit: active-low release for logic clocked by the MMCM outputs.
REQ-009 SHALL have port o_state, output, 2 bits: current state, encoded RESET_PULSE=0, WAIT_LOCK=1, STABLE=2, RUN=3.
REQ-010 SHALL have port o_retry_cnt, output, 8 bits: count of lock timeouts.

Function
REQ-011 SHALL pass i_locked through a two-flop synchronizer; all decisions use the synchronized value lk, which lags i_locked by 2 cycles.
REQ-012 SHALL use one shared 24-bit cycle counter, cleared on every state transition.
REQ-013 RESET_PULSE SHALL hold o_mmcm_rst=1 and o_rst_n=0, then move to WAIT_LOCK on the edge where counter==RST_CYCLES-1; o_mmcm_rst SHALL be 1 for exactly RST_CYCLES cycles.
REQ-014 In WAIT_LOCK, o_mmcm_rst SHALL be 0; lk==1 SHALL move to STABLE; otherwise counter==LOCK_TIMEOUT-1 SHALL move to RESET_PULSE.
REQ-015 In WAIT_LOCK, lk==1 and timeout in the same cycle SHALL go to STABLE.
REQ-016 In STABLE, lk==0 SHALL move to RESET_PULSE; counter==STABLE_CYCLES-1 with lk==1 SHALL move to RUN.
REQ-017 In RUN, o_rst_n SHALL be 1 and o_mmcm_rst 0; lk==0 SHALL move to RESET_PULSE.
REQ-018 o_rst_n SHALL rise on the same edge that enters RUN.
REQ-019 o_rst_n SHALL fall and o_mmcm_rst SHALL rise on the same edge that leaves RUN.
REQ-020 All outputs SHALL be registered with no combinational path from i_locked.

Reset
REQ-021 While i_rst_n==0 at a rising edge, the block SHALL load state RESET_PULSE, counter=0, o_mmcm_rst=1, o_rst_n=0, o_retry_cnt=0 and synchronizer flops=0.
REQ-022 Reset asserted mid-operation, including during RUN, SHALL take effect on the next edge and restart the full sequence.

Configuration
REQ-023 With macro MMCM_RETRY_CNT_EN defined, o_retry_cnt SHALL increment by 1 on each WAIT_LOCK timeout and saturate at 255.
REQ-024 Lock losses in STABLE or RUN SHALL NOT increment o_retry_cnt.
REQ-025 With MMCM_RETRY_CNT_EN undefined, o_retry_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8)
REQ-026 Release reset with i_locked=1 constant -> o_mmcm_rst high for exactly 4 cycles; o_rst_n rises once, after sequence 0,1,2,3 on o_state.
REQ-027 i_locked=0 for 250 cycles after reset -> o_mmcm_rst re-pulses after each 100-cycle wait; o_retry_cnt=2 with macro, 0 without.
REQ-028 In RUN, drop i_locked for 1 cycle -> 2 cycles later, same edge: o_rst_n=0, o_mmcm_rst=1, o_state=0.
REQ-029 In STABLE, drop i_locked at cycle 5 -> return to RESET_PULSE, o_rst_n never rises, o_retry_cnt unchanged.
REQ-030 Force 300 timeouts (macro on) -> o_retry_cnt holds at 255 with no wrap.
REQ-031 Assert i_rst_n=0 in RUN for 1 cycle -> next edge: o_rst_n=0, o_mmcm_rst=1, o_retry_cnt=0.
